// File: rtl/fifo_uart_tx.sv
// ============================================================================
// Module   : fifo_uart_tx
// Purpose  : Drains an 8-bit byte FIFO onto a UART line (8N1, LSB first).
//            Define FIFO_UART_TX_PARITY_EN to add an even-parity bit (8E1).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        fifo_empty,
  input  logic [7:0]  fifo_dout,
  output logic        fifo_rd_en,
  output logic        tx,
  output logic        busy,
  output logic        tx_done,
  output logic [15:0] bytes_sent
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] WAIT   = 3'd1;
  localparam logic [2:0] START  = 3'd2;
  localparam logic [2:0] DATA   = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;
`ifdef FIFO_UART_TX_PARITY_EN
  localparam logic [2:0] PARITY = 3'd5;
`endif

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             tx_q, tx_d;
  logic [15:0]      bytes_q, bytes_d;
  logic             bit_end;

  assign bit_end    = (cnt_q == CNT_LAST);
  assign fifo_rd_en = (state_q == IDLE) && en && !fifo_empty;
  assign busy       = (state_q != IDLE);
  assign tx_done    = (state_q == STOP) && bit_end;
  assign tx         = tx_q;
  assign bytes_sent = bytes_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    idx_d   = idx_q;
    shift_d = shift_q;
    bytes_d = bytes_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (fifo_rd_en) state_d = WAIT;
      end
      WAIT: begin
        // Read data is registered in the FIFO, so it is valid only now.
        shift_d = fifo_dout;
        cnt_d   = '0;
        state_d = START;
      end
      START: begin
        if (bit_end) begin
          cnt_d   = '0;
          idx_d   = 3'd0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_d = '0;
          if (idx_q == 3'd7) begin
`ifdef FIFO_UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
`ifdef FIFO_UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          cnt_d   = '0;
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        if (bit_end) begin
          cnt_d   = '0;
          bytes_d = bytes_q + 16'd1;
          state_d = IDLE;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // Line level is derived from the next state so tx changes on the same edge as the state.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[idx_d];
`ifdef FIFO_UART_TX_PARITY_EN
      PARITY:  tx_d = ^shift_d;
`endif
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= 3'd0;
      shift_q <= 8'd0;
      tx_q    <= 1'b1;
      bytes_q <= 16'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      bytes_q <= bytes_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fifo_uart_tx.sv
// ============================================================================
// Module   : tb_fifo_uart_tx
// Purpose  : Scoreboard bench for fifo_uart_tx with a FIFO model and a UART
//            line receiver; honours FIFO_UART_TX_PARITY_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fifo_uart_tx;

  localparam int CPB = 4;
`ifdef FIFO_UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        fifo_empty = 1'b1;
  logic [7:0]  fifo_dout = 8'd0;
  logic        fifo_rd_en;
  logic        tx;
  logic        busy;
  logic        tx_done;
  logic [15:0] bytes_sent;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int pop_cyc = -100;
  int model_sent = 0;
  logic [7:0] fq[$];
  logic [7:0] push_q[$];
  logic [7:0] exp_q[$];
  int starts[$];

  fifo_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .fifo_empty (fifo_empty),
    .fifo_dout  (fifo_dout),
    .fifo_rd_en (fifo_rd_en),
    .tx         (tx),
    .busy       (busy),
    .tx_done    (tx_done),
    .bytes_sent (bytes_sent)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // FIFO with registered read data; pushes become visible one edge after request.
  always @(posedge clk) begin
    if (fifo_rd_en && fq.size() > 0) fifo_dout <= fq.pop_front();
    while (push_q.size() > 0) fq.push_back(push_q.pop_front());
    fifo_empty <= (fq.size() == 0);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic note_pop();
    if (fifo_rd_en === 1'b1) begin
      pop_cyc = cyc;
      check("rd_en_while_empty", {31'd0, fifo_empty}, 32'd0);
    end
  endtask

  task automatic run_frame();
    logic [7:0]  b;
    logic [10:0] bits;
    logic        got;
    logic        bad_ctl;
    int          start_c;
    int          done_c;
    int          done_n;
    start_c = cyc;
    starts.push_back(start_c);
    check("pop_to_tx_latency", start_c - pop_cyc, 32'd2);
    if (exp_q.size() == 0) begin
      check("unexpected_frame", 32'd1, 32'd0);
      b = 8'd0;
    end else begin
      b = exp_q.pop_front();
    end
`ifdef FIFO_UART_TX_PARITY_EN
    bits = {1'b1, ^b, b, 1'b0};
`else
    bits = {1'b0, 1'b1, b, 1'b0};
`endif
    done_c  = -1;
    done_n  = 0;
    bad_ctl = 1'b0;
    for (int i = 0; i < NB; i++) begin
      got = bits[i];
      for (int c = 0; c < CPB; c++) begin
        if (i != 0 || c != 0) begin
          @(negedge clk);
          if (rst) begin
            // Reset edge follows; the frame is abandoned without counting.
            @(negedge clk);
            check("rst_tx", {31'd0, tx}, 32'd1);
            check("rst_busy", {31'd0, busy}, 32'd0);
            check("rst_bytes_sent", {16'd0, bytes_sent}, 32'd0);
            model_sent = 0;
            if (!rst) note_pop();
            return;
          end
        end
        if (tx !== bits[i]) got = tx;
        if (tx_done === 1'b1) begin
          done_c = cyc;
          done_n++;
        end
        if (busy !== 1'b1 || fifo_rd_en !== 1'b0) bad_ctl = 1'b1;
      end
      check($sformatf("byte_%02h_bit%0d", b, i), {31'd0, got}, {31'd0, bits[i]});
    end
    check("tx_done_pulses", done_n, 32'd1);
    check("frame_length", done_c - start_c + 1, NB * CPB);
    check("busy_and_no_pop_in_frame", {31'd0, bad_ctl}, 32'd0);
    @(negedge clk);
    model_sent = (model_sent + 1) & 16'hFFFF;
    check("bytes_sent", {16'd0, bytes_sent}, model_sent);
    if (rst) model_sent = 0;
    else note_pop();
  endtask

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (rst) begin
        model_sent = 0;
      end else begin
        note_pop();
        if (tx === 1'b0) run_frame();
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_b(input logic [7:0] b);
    push_q.push_back(b);
    exp_q.push_back(b);
  endtask

  task automatic do_reset();
    en  = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_idle(input int limit);
    int n;
    n = 0;
    while (n < limit && !(push_q.size() == 0 && fifo_empty && !busy && !fifo_rd_en)) begin
      tick();
      n++;
    end
    check("drain_timeout", {31'd0, n >= limit}, 32'd0);
    tick();
    tick();
  endtask

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    logic bad;
    int   n;
    logic seen;

    repeat (3) tick();
    check("reset_tx", {31'd0, tx}, 32'd1);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_tx_done", {31'd0, tx_done}, 32'd0);
    check("reset_bytes_sent", {16'd0, bytes_sent}, 32'd0);
    check("reset_rd_en", {31'd0, fifo_rd_en}, 32'd0);
    rst = 1'b0;
    tick();

    // Single byte 0xA5.
    push_b(8'hA5);
    tick();
    en = 1'b1;
    wait_idle(200);
    check("t1_bytes_sent", {16'd0, bytes_sent}, 32'd1);

    // Three back-to-back frames with two idle cycles in between.
    do_reset();
    push_b(8'h01);
    push_b(8'hFF);
    push_b(8'h80);
    tick();
    starts.delete();
    en = 1'b1;
    wait_idle(600);
    check("t2_bytes_sent", {16'd0, bytes_sent}, 32'd3);
    check("t2_frames", starts.size(), 32'd3);
    if (starts.size() == 3) begin
      check("t2_gap01", starts[1] - starts[0], NB * CPB + 2);
      check("t2_gap12", starts[2] - starts[1], NB * CPB + 2);
    end

    // en held low with data waiting.
    do_reset();
    push_b(8'h5E);
    push_b(8'h81);
    tick();
    bad = 1'b0;
    repeat (50) begin
      tick();
      if (fifo_rd_en !== 1'b0 || tx !== 1'b1 || busy !== 1'b0) bad = 1'b1;
    end
    check("t3_quiet_while_en_low", {31'd0, bad}, 32'd0);
    en   = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick();
      if (busy === 1'b1) seen = 1'b1;
    end
    check("t3_start_after_en", {31'd0, seen}, 32'd1);
    wait_idle(600);

    // Reset during data bit 3 of 0x3C, then the next byte goes out fresh.
    do_reset();
    push_b(8'h3C);
    push_b(8'h99);
    en = 1'b1;
    n  = 0;
    while (n < 20 && fifo_rd_en !== 1'b1) begin
      tick();
      n++;
    end
    check("t4_pop_timeout", {31'd0, n >= 20}, 32'd0);
    repeat (2 + 4 * CPB + 1) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    wait_idle(400);
    check("t4_bytes_after_reset", {16'd0, bytes_sent}, 32'd1);

    // en dropped during START: frame completes, then the block stays idle.
    do_reset();
    push_b(8'h5A);
    push_b(8'hC3);
    tick();
    en = 1'b1;
    n  = 0;
    while (n < 20 && fifo_rd_en !== 1'b1) begin
      tick();
      n++;
    end
    tick();
    tick();
    tick();
    en = 1'b0;
    n  = 0;
    while (n < 200 && tx_done !== 1'b1) begin
      tick();
      n++;
    end
    check("t5_done_timeout", {31'd0, n >= 200}, 32'd0);
    bad = 1'b0;
    repeat (20) begin
      tick();
      if (busy !== 1'b0 || fifo_rd_en !== 1'b0 || tx !== 1'b1) bad = 1'b1;
    end
    check("t5_stays_idle", {31'd0, bad}, 32'd0);
    check("t5_bytes_sent", {16'd0, bytes_sent}, 32'd1);
    en = 1'b1;
    wait_idle(400);

`ifdef FIFO_UART_TX_PARITY_EN
    do_reset();
    push_b(8'hA5);
    push_b(8'h07);
    tick();
    en = 1'b1;
    wait_idle(400);
    check("t6_bytes_sent", {16'd0, bytes_sent}, 32'd2);
`endif

    // Random bytes with en toggling.
    do_reset();
    for (int i = 0; i < 24; i++) begin
      push_b(8'($urandom));
      repeat ($urandom_range(0, 30)) begin
        tick();
        en = ($urandom_range(0, 9) < 8);
      end
    end
    en = 1'b1;
    wait_idle(3000);
    check("rand_bytes_sent", {16'd0, bytes_sent}, 32'd24);
    check("scoreboard_empty", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fifo_uart_tx.md
Name: fifo_uart_tx

Overview:
Downstream drain stage for the 8-bit byte FIFO. It pops bytes through the FIFO read port (fifo_rd_en, fifo_empty, fifo_dout) and serializes each byte onto a single UART line, 8N1 format, LSB first. The stage owns the only read port of the FIFO. The FIFO presents registered read data one cycle after a pop.

Parameters:
CLKS_PER_BIT, 16, clk cycles per UART bit; legal range 2..65535; the bit counter is $clog2(CLKS_PER_BIT) bits wide.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous reset, active-high
en  input  1  permits starting a new frame; sampled only in IDLE
fifo_empty  input  1  upstream FIFO empty flag
fifo_dout  input  8  upstream FIFO read data; valid the cycle after a pop
fifo_rd_en  output  1  pop strobe to the FIFO
tx  output  1  serial line, idle high, registered
busy  output  1  high in any state other than IDLE
tx_done  output  1  one-cycle pulse when the stop bit completes
bytes_sent  output  16  count of completed frames

Behaviour:
- Reset: synchronous, active-high, highest priority.
  - Values: tx=1, fifo_rd_en=0, busy=0, tx_done=0, bytes_sent=0, state=IDLE, bit counter=0, shift register=0.
  - Reset mid-frame abandons the frame; tx returns high at that edge; bytes_sent is not incremented.
- States: IDLE, WAIT, START, DATA, STOP (plus PARITY when the optional feature is compiled in).
- fifo_rd_en is combinational, equal to (state==IDLE) && en && !fifo_empty.
  - It is high for at most one cycle per frame.
  - It is never asserted while fifo_empty=1.
- IDLE: tx=1. If fifo_rd_en, go to WAIT; otherwise stay in IDLE.
- WAIT: exactly one cycle. fifo_dout is captured into the shift register at the end of WAIT, then go to START.
- Pop-to-line latency: tx falls at the second rising edge after the cycle in which fifo_rd_en is high.
- START: tx=0 for CLKS_PER_BIT cycles.
- DATA: 8 bits, LSB first, each held for CLKS_PER_BIT cycles; a 3-bit index counts 0..7.
- STOP: tx=1 for CLKS_PER_BIT cycles.
  - On its last cycle, tx_done=1 for exactly that cycle and bytes_sent increments; then go to IDLE.
- Frame length: 10*CLKS_PER_BIT cycles from tx falling to the end of the stop bit.
- Back-to-back frames: IDLE can pop on the first cycle after STOP, so the line idles high for 2 clk cycles between consecutive stop and start bits.
- en low mid-frame: the current frame completes normally; no new pop occurs while en=0.
- fifo_empty rising mid-frame: ignored; the byte is already captured.
- bytes_sent wraps from 0xFFFF to 0x0000.
- busy is combinational from the state: 0 only in IDLE.
- The bit counter resets to 0 on every state transition; the state advances when the counter equals CLKS_PER_BIT-1.

Optional Feature:
Macro FIFO_UART_TX_PARITY_EN.
- Defined: a PARITY state is inserted between DATA and STOP.
  - tx carries even parity (XOR of the 8 data bits) for CLKS_PER_BIT cycles.
  - Frame length becomes 11*CLKS_PER_BIT cycles.
- Undefined: no PARITY state and no parity logic; DATA goes directly to STOP (8N1).

Test Plan:
1. CLKS_PER_BIT=4, FIFO holds 0xA5, en=1.
   - fifo_rd_en is high for one cycle.
   - tx falls 2 edges later.
   - tx bit sequence is 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles.
   - tx_done pulses once; bytes_sent=1.
2. FIFO holds 0x01, 0xFF, 0x80 with en=1.
   - Three frames go out with exactly 2 idle cycles between them.
   - bytes_sent=3.
   - fifo_rd_en never pulses while fifo_empty=1.
3. en=0 with a non-empty FIFO for 50 cycles: no pop, tx=1, busy=0. Raise en: a frame starts within 2 cycles.
4. Assert rst during DATA bit 3 of 0x3C.
   - Next edge: tx=1, busy=0, bytes_sent=0.
   - After rst is released with en=1 and the FIFO non-empty, a fresh frame for the next byte starts.
5. Drop en during the START bit: the frame completes fully, then the block stays in IDLE.
6. With FIFO_UART_TX_PARITY_EN defined, send 0xA5 then 0x07.
   - Parity bits are 0 then 1.
   - Each frame is 44 cycles at CLKS_PER_BIT=4.
